// File: rtl/pdff_pipe_pkg.sv
// Decoder common package: shared helpers for the elastic register pipeline.
// Provides the ceiling-log2 used to size occupancy counters.
package pdff_pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pdff_pipe_if.sv
// Handshake bundle for pdff_pipe: input/output valid-ready pair, flush and occupancy.
// The master side is the upstream/downstream environment, the slave side is the pipeline.
interface pdff_pipe_if
  import pdff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] qout;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport master (
    output data, in_valid, out_ready, flush,
    input  in_ready, qout, out_valid, count
  );

  modport slave (
    input  data, in_valid, out_ready, flush,
    output in_ready, qout, out_valid, count
  );

endinterface

// File: rtl/pdff_pipe_stage.sv
// pdff_stage: one pipeline slot, a WIDTH-bit data register plus its valid bit.
// Flush clears only the valid bit; the data register is don't-care while invalid.
module pdff_stage #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_v,
  output logic [WIDTH-1:0] o_d,
  output logic             o_v
);

  logic [WIDTH-1:0] r_d;
  logic             r_v;

  // Slot register: reset clears everything, flush drops the word, enable loads from upstream.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_d <= '0;
      r_v <= 1'b0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_en) begin
      r_d <= i_d;
      r_v <= i_v;
    end
  end

  assign o_d = r_d;
  assign o_v = r_v;

endmodule

// File: rtl/pdff_pipe.sv
// pdff_pipe: DEPTH-stage elastic register pipeline with valid/ready handshake,
// bubble collapse, synchronous flush and a registered occupancy count.
module pdff_pipe
  import pdff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pdff_pipe_if.slave    io_bus
);

  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0] w_en;
  logic [DEPTH-1:0] w_sv;
  logic [WIDTH-1:0] w_sd   [DEPTH];
  logic [WIDTH-1:0] w_ld_d [DEPTH];
  logic [DEPTH-1:0] w_ld_v;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_count;

  // A stage may load whenever some slot at or beyond it is empty or the output drains;
  // computed per stage so there is no long combinational chain through one vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign w_en[g] = io_bus.out_ready | ~(&w_sv[DEPTH-1:g]);

    pdff_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (io_bus.flush),
      .i_en    (w_en[g]),
      .i_d     (w_ld_d[g]),
      .i_v     (w_ld_v[g]),
      .o_d     (w_sd[g]),
      .o_v     (w_sv[g])
    );
  end

  // Stage load sources: stage 0 takes the input port, every other stage its predecessor.
  always_comb begin
    w_ld_d[0] = io_bus.data;
    w_ld_v[0] = io_bus.in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      w_ld_d[i] = w_sd[i-1];
      w_ld_v[i] = w_sv[i-1];
    end
  end

  // Handshake qualifiers and next occupancy.
  always_comb begin
    w_in_ready  = w_en[0] & ~io_bus.flush;
    w_in_xfer   = io_bus.in_valid & w_in_ready;
    w_out_xfer  = w_sv[DEPTH-1] & io_bus.out_ready;
    w_count_nxt = r_count + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
  end

  // Occupancy counter; flush empties the pipe even if a word was consumed the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (io_bus.flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.qout      = w_sd[DEPTH-1];
  assign io_bus.out_valid = w_sv[DEPTH-1];
  assign io_bus.count     = r_count;

endmodule

// File: tb/tb_pdff_pipe.sv
// Self-checking bench for pdff_pipe: directed scenarios plus randomized traffic
// against a queue model where each word tracks its stage position.
module tb_pdff_pipe;
  import pdff_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [WIDTH-1:0] m_data[$];
  int               m_pos[$];

  always #5 clk = ~clk;

  pdff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pdff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  // Pipe accepts when not flushing and either some slot is free or the output drains.
  function automatic logic m_in_ready();
    return !bus.flush && (bus.out_ready || (m_data.size() < DEPTH));
  endfunction

  // Head word is visible once it has reached the last stage.
  function automatic logic m_out_valid();
    return (m_data.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  // Advance one clock; each word moves one stage unless packed against the words ahead of it.
  task automatic tick();
    logic push, pop;
    int   lim;
    push = bus.in_valid && m_in_ready();
    pop  = m_out_valid() && bus.out_ready;
    @(posedge clk);
    #1;
    if (!rst_n || bus.flush) begin
      m_data.delete();
      m_pos.delete();
    end else begin
      if (pop) begin
        void'(m_data.pop_front());
        void'(m_pos.pop_front());
      end
      for (int k = 0; k < m_pos.size(); k++) begin
        lim = DEPTH - 1 - k;
        m_pos[k] = (m_pos[k] + 1 > lim) ? lim : m_pos[k] + 1;
      end
      if (push) begin
        m_data.push_back(bus.data);
        m_pos.push_back(0);
      end
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.data = 8'hA5; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.qout !== 8'h00) begin n_err++; $display("FAIL reset_qout got %h exp 00", bus.qout); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.count !== '0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    int exp_cnt;
    bus.out_ready = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      bus.in_valid = (t <= 16);
      bus.data     = WIDTH'(t);
      tick();
      exp_cnt = ((t < 16) ? t : 16) - ((t > 4) ? t - 4 : 0);
      n_vec++;
      if (bus.out_valid !== (t >= 4)) begin
        n_err++; $display("FAIL stream_valid t=%0d got %b exp %b", t, bus.out_valid, (t >= 4));
      end
      if (t >= 4) begin
        n_vec++;
        if (bus.qout !== WIDTH'(t - 3)) begin
          n_err++; $display("FAIL stream_data t=%0d got %h exp %h", t, bus.qout, WIDTH'(t - 3));
        end
      end
      n_vec++;
      if (bus.count !== CNT_W'(exp_cnt)) begin
        n_err++; $display("FAIL stream_count t=%0d got %0d exp %0d", t, bus.count, exp_cnt);
      end
    end
    drain();
  endtask

  task automatic test_stall_fill();
    logic [WIDTH-1:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = 1'b1; bus.data = vals[j];
      #1;
      n_vec++;
      if (bus.in_ready !== (j < 4)) begin
        n_err++; $display("FAIL stall_in_ready j=%0d got %b exp %b", j, bus.in_ready, (j < 4));
      end
      tick();
    end
    n_vec++; if (bus.count !== CNT_W'(4)) begin n_err++; $display("FAIL stall_count got %0d exp 4", bus.count); end
    bus.out_ready = 1'b1; bus.data = 8'h55;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b exp 1", bus.in_ready); end
    for (int j = 0; j < 5; j++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.qout !== vals[j]) begin
        n_err++; $display("FAIL stall_drain j=%0d got v=%b %h exp v=1 %h", j, bus.out_valid, bus.qout, vals[j]);
      end
      tick();
      bus.in_valid = 1'b0;
    end
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== '0) begin
      n_err++; $display("FAIL stall_empty got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.data = 8'h0A; tick();
    bus.in_valid = 1'b0; tick(); tick();
    bus.in_valid = 1'b1; bus.data = 8'h0B; tick();
    bus.in_valid = 1'b0; tick(); tick(); tick();
    n_vec++; if (bus.count !== CNT_W'(2)) begin n_err++; $display("FAIL bubble_count got %0d exp 2", bus.count); end
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.qout !== 8'h0A) begin
      n_err++; $display("FAIL bubble_first got v=%b %h exp v=1 0a", bus.out_valid, bus.qout);
    end
    bus.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.qout !== 8'h0B) begin
      n_err++; $display("FAIL bubble_second got v=%b %h exp v=1 0b", bus.out_valid, bus.qout);
    end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_full_pushpop();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    repeat (DEPTH) begin bus.data = WIDTH'($urandom); tick(); end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      bus.data = WIDTH'($urandom);
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.count !== CNT_W'(DEPTH) || bus.qout !== m_data[0]) begin
        n_err++; $display("FAIL full_pushpop j=%0d got rdy=%b cnt=%0d q=%h exp rdy=1 cnt=%0d q=%h",
                          j, bus.in_ready, bus.count, bus.qout, DEPTH, m_data[0]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin bus.data = WIDTH'($urandom_range(0, 63)); tick(); end
    n_vec++; if (bus.count !== CNT_W'(3)) begin n_err++; $display("FAIL flush_pre_count got %0d exp 3", bus.count); end
    bus.flush = 1'b1; bus.data = 8'h77;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_vec++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_cleared got cnt=%0d v=%b exp cnt=0 v=0", bus.count, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) begin
      tick();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost got v=%b q=%h exp v=0", bus.out_valid, bus.qout); end
    end
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin bus.data = WIDTH'($urandom_range(1, 63)); tick(); end
    rst_n = 1'b0; bus.flush = 1'b1; bus.data = 8'h77;
    tick();
    rst_n = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.qout !== 8'h00 || bus.out_valid !== 1'b0 || bus.count !== '0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_flush got q=%h v=%b cnt=%0d rdy=%b exp q=00 v=0 cnt=0 rdy=1",
                        bus.qout, bus.out_valid, bus.count, bus.in_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.data      = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      #1;
      n_vec++;
      if (bus.in_ready !== m_in_ready() || bus.out_valid !== m_out_valid() ||
          bus.count !== CNT_W'(m_data.size())) begin
        n_err++; $display("FAIL random_ctrl c=%0d got rdy=%b v=%b cnt=%0d exp rdy=%b v=%b cnt=%0d", c,
                          bus.in_ready, bus.out_valid, bus.count, m_in_ready(), m_out_valid(), m_data.size());
      end
      if (m_out_valid()) begin
        n_vec++;
        if (bus.qout !== m_data[0]) begin
          n_err++; $display("FAIL random_data c=%0d got %h exp %h", c, bus.qout, m_data[0]);
        end
      end
      tick();
    end
    bus.flush = 1'b0;
    drain();
  endtask

  initial begin
    bus.data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_bubble();
    test_full_pushpop();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
